// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and data-memory buses around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_ack_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [1:0]        grant_o;
    logic [31:0]       stall_cnt_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, mem_rdata_i,
        output cpu_rdata_o, cpu_stall_o, dbg_rdata_o, dbg_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, grant_o, stall_cnt_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, mem_rdata_i,
        input  cpu_rdata_o, cpu_stall_o, dbg_rdata_o, dbg_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, grant_o, stall_cnt_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data-memory port between the CPU MEM stage and a debug port.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_arbiter_if.slave   bus
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d, last_q, last_d, we_q, we_d; // owner/last: 1 = debug
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic              stall, pick_dbg;

    always_comb begin
        stall       = bus.cpu_req_i & ~(state_q == DONE & ~owner_q);
        pick_dbg    = bus.dbg_req_i & (~bus.cpu_req_i | ~last_q);
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        unique case (state_q)
            IDLE: if (bus.cpu_req_i | bus.dbg_req_i) begin
                owner_d = pick_dbg;
                last_d  = pick_dbg;
                we_d    = pick_dbg ? bus.dbg_we_i    : bus.cpu_we_i;
                addr_d  = pick_dbg ? bus.dbg_addr_i  : bus.cpu_addr_i;
                wdata_d = pick_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d     = DONE;
                cpu_rdata_d = (!we_q && !owner_q) ? bus.mem_rdata_i : cpu_rdata_q;
                dbg_rdata_d = (!we_q &&  owner_q) ? bus.mem_rdata_i : dbg_rdata_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.cpu_stall_o = stall;
    assign bus.cpu_rdata_o = cpu_rdata_q;
    assign bus.dbg_rdata_o = dbg_rdata_q;
    assign bus.dbg_ack_o   = state_q == DONE & owner_q;
    assign bus.mem_en_o    = state_q == ACCESS;
    assign bus.mem_we_o    = state_q == ACCESS & we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.grant_o     = state_q == IDLE ? 2'b00 : {owner_q, ~owner_q};
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a transaction-timeline model.
module tb_dmem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    // Memory word i holds i+5 after every reset.
    logic [31:0] mem [64];
    always @(posedge clk)
        if (rst) for (int i = 0; i < 64; i++) mem[i] <= 32'(i) + 32'd5;
        else if (bus.mem_en_o && bus.mem_we_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    int vectors = 0;
    int miscompares = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = 0; bus.cpu_wdata_i = 0;
        bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_addr_i = 0; bus.dbg_wdata_i = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic rand_inputs;
        bus.cpu_req_i = 1'($urandom_range(1)); bus.cpu_we_i = 1'($urandom_range(1));
        bus.cpu_addr_i = $urandom; bus.cpu_wdata_i = $urandom;
        bus.dbg_req_i = 1'($urandom_range(1)); bus.dbg_we_i = 1'($urandom_range(1));
        bus.dbg_addr_i = $urandom; bus.dbg_wdata_i = $urandom;
    endtask

    task automatic test_reset;
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            rand_inputs();
            step();
            @(negedge clk);
            vectors++;
            if ({bus.mem_en_o, bus.mem_we_o, bus.dbg_ack_o, bus.grant_o} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl c=%0d got en/we/ack/grant=%b exp=00000", c,
                         {bus.mem_en_o, bus.mem_we_o, bus.dbg_ack_o, bus.grant_o});
            end
            vectors++;
            if ({bus.mem_addr_o, bus.mem_wdata_o, bus.cpu_rdata_o, bus.dbg_rdata_o, bus.stall_cnt_o} !== 160'b0) begin
                miscompares++;
                $display("FAIL reset_regs c=%0d addr=%h wdata=%h crd=%h drd=%h scnt=%0d exp all 0", c,
                         bus.mem_addr_o, bus.mem_wdata_o, bus.cpu_rdata_o, bus.dbg_rdata_o, bus.stall_cnt_o);
            end
            vectors++;
            if (bus.cpu_stall_o !== bus.cpu_req_i) begin
                miscompares++;
                $display("FAIL reset_stall got=%b exp=%b", bus.cpu_stall_o, bus.cpu_req_i);
            end
        end
        rst = 0;
        idle_inputs();
        step();
    endtask

    task automatic test_cpu_load;
        do_reset();
        bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 32'h0;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.cpu_stall_o !== (c <= LAT)) begin
                miscompares++;
                $display("FAIL load_stall c=%0d got=%b exp=%b", c, bus.cpu_stall_o, c <= LAT);
            end
            vectors++;
            if (bus.mem_en_o !== (c >= 1 && c <= LAT)) begin
                miscompares++;
                $display("FAIL load_en c=%0d got=%b exp=%b", c, bus.mem_en_o, c >= 1 && c <= LAT);
            end
            if (c == LAT + 1) begin
                vectors++;
                if (bus.cpu_rdata_o !== 32'd5) begin
                    miscompares++;
                    $display("FAIL load_rdata got=%h exp=5", bus.cpu_rdata_o);
                end
                vectors++;
                if (bus.stall_cnt_o !== 32'(LAT + 1)) begin
                    miscompares++;
                    $display("FAIL load_stall_cnt got=%0d exp=%0d", bus.stall_cnt_o, LAT + 1);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_arbitration;
        logic [1:0] eg;
        do_reset();
        bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 32'h08;
        bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 32'h04;
        for (int c = 0; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            eg = (c >= 1 && c <= LAT + 1) ? 2'b01 : (c >= LAT + 3 && c <= 2 * LAT + 3) ? 2'b10 : 2'b00;
            vectors++;
            if (bus.grant_o !== eg) begin
                miscompares++;
                $display("FAIL arb_grant c=%0d got=%b exp=%b", c, bus.grant_o, eg);
            end
            vectors++;
            if (bus.dbg_ack_o !== (c == 2 * LAT + 3)) begin
                miscompares++;
                $display("FAIL arb_ack c=%0d got=%b exp=%b", c, bus.dbg_ack_o, c == 2 * LAT + 3);
            end
            vectors++;
            if (bus.mem_en_o !== ((c >= 1 && c <= LAT) || (c >= LAT + 3 && c <= 2 * LAT + 2))) begin
                miscompares++;
                $display("FAIL arb_en c=%0d got=%b", c, bus.mem_en_o);
            end
            if (c == 2 * LAT + 3) begin
                vectors++;
                if (bus.dbg_rdata_o !== 32'd6 || bus.cpu_rdata_o !== 32'd7) begin
                    miscompares++;
                    $display("FAIL arb_rdata dbg=%h cpu=%h exp dbg=6 cpu=7", bus.dbg_rdata_o, bus.cpu_rdata_o);
                end
            end
            step();
            if (c == LAT + 1) bus.cpu_req_i = 0;
            if (c == 2 * LAT + 3) bus.dbg_req_i = 0;
        end
        idle_inputs();
    endtask

    task automatic test_alternate;
        logic [1:0] eg;
        do_reset();
        bus.cpu_req_i = 1; bus.dbg_req_i = 1;
        bus.cpu_addr_i = 32'h20; bus.dbg_addr_i = 32'h24;
        for (int c = 0; c < 4 * (LAT + 2); c++) begin
            @(negedge clk);
            if (c % (LAT + 2) == 1) begin
                eg = ((c / (LAT + 2)) % 2 == 0) ? 2'b01 : 2'b10;
                vectors++;
                if (bus.grant_o !== eg) begin
                    miscompares++;
                    $display("FAIL alt_grant txn=%0d got=%b exp=%b", c / (LAT + 2), bus.grant_o, eg);
                end
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_dbg_write;
        int acks = 0, ens = 0;
        do_reset();
        bus.dbg_req_i = 1; bus.dbg_we_i = 1; bus.dbg_addr_i = 32'h1C; bus.dbg_wdata_i = 32'hDEADBEEF;
        for (int c = 0; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (bus.mem_en_o) begin
                ens++;
                vectors++;
                if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 32'h1C, 32'hDEADBEEF}) begin
                    miscompares++;
                    $display("FAIL wr_bus c=%0d we=%b addr=%h wdata=%h exp 1/1c/deadbeef", c,
                             bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
                end
            end
            acks += int'(bus.dbg_ack_o);
            step();
            if (c == LAT + 1) bus.dbg_req_i = 0;
        end
        vectors++;
        if (acks !== 1 || ens !== LAT) begin
            miscompares++;
            $display("FAIL wr_counts acks=%0d en_cycles=%0d exp 1/%0d", acks, ens, LAT);
        end
        vectors++;
        if (bus.dbg_rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_rdata got=%h exp=0", bus.dbg_rdata_o);
        end
        vectors++;
        if (mem[7] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_mem got=%h exp=deadbeef", mem[7]);
        end
        idle_inputs();
    endtask

    task automatic test_reset_abort;
        int stalls = 0;
        do_reset();
        bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 32'h10; bus.cpu_wdata_i = 32'h1234_5678;
        step();
        rst = 1;
        @(negedge clk);
        vectors++;
        if (bus.mem_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_first_access got en=%b exp=1", bus.mem_en_o);
        end
        step();
        rst = 0;
        bus.cpu_we_i = 0; bus.cpu_addr_i = 32'h0C;
        @(negedge clk);
        vectors++;
        if ({bus.mem_en_o, bus.grant_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_idle got en/grant=%b exp=000", {bus.mem_en_o, bus.grant_o});
        end
        while (bus.cpu_stall_o && stalls < 20) begin
            stalls++;
            step();
            @(negedge clk);
        end
        vectors++;
        if (stalls !== LAT + 1) begin
            miscompares++;
            $display("FAIL abort_reload_stall got=%0d exp=%0d", stalls, LAT + 1);
        end
        vectors++;
        if (bus.cpu_rdata_o !== 32'd8 || bus.stall_cnt_o !== 32'(LAT + 1)) begin
            miscompares++;
            $display("FAIL abort_reload_data rdata=%h scnt=%0d exp 8/%0d", bus.cpu_rdata_o, bus.stall_cnt_o, LAT + 1);
        end
        step();
        idle_inputs();
    endtask

    // Model: each transaction is a timeline from its grant cycle; phases 1..LAT access, LAT+1 done.
    task automatic test_random;
        logic [31:0] shadow [64];
        int gt = -1, ph;
        bit who = 0, last = 1, twe = 0;
        logic [31:0] taddr = 0, twd = 0, e_cr = 0, e_dr = 0, e_sc = 0;
        logic e_en, e_done, e_stall, e_ack;
        logic [1:0] e_gr;
        do_reset();
        for (int i = 0; i < 64; i++) shadow[i] = 32'(i) + 32'd5;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            ph = gt < 0 ? 0 : cyc - gt;
            e_en = ph >= 1 && ph <= LAT;
            e_done = ph == LAT + 1;
            e_gr = ph >= 1 ? (who ? 2'b10 : 2'b01) : 2'b00;
            e_stall = bus.cpu_req_i && !(e_done && !who);
            e_ack = e_done && who;
            vectors++;
            if ({bus.mem_en_o, bus.grant_o, bus.cpu_stall_o, bus.dbg_ack_o} !== {e_en, e_gr, e_stall, e_ack}) begin
                miscompares++;
                $display("FAIL rnd_ctrl cyc=%0d en/grant/stall/ack got=%b exp=%b", cyc,
                         {bus.mem_en_o, bus.grant_o, bus.cpu_stall_o, bus.dbg_ack_o}, {e_en, e_gr, e_stall, e_ack});
            end
            if (e_en) begin
                vectors++;
                if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {twe, taddr, twd}) begin
                    miscompares++;
                    $display("FAIL rnd_bus cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc,
                             bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, twe, taddr, twd);
                end
            end
            vectors++;
            if ({bus.cpu_rdata_o, bus.dbg_rdata_o, bus.stall_cnt_o} !== {e_cr, e_dr, e_sc}) begin
                miscompares++;
                $display("FAIL rnd_data cyc=%0d got crd=%h drd=%h scnt=%0d exp %h %h %0d", cyc,
                         bus.cpu_rdata_o, bus.dbg_rdata_o, bus.stall_cnt_o, e_cr, e_dr, e_sc);
            end
            if (e_stall) e_sc++;
            if (ph == LAT) begin
                if (twe) shadow[taddr[7:2]] = twd;
                else if (who) e_dr = shadow[taddr[7:2]];
                else e_cr = shadow[taddr[7:2]];
            end
            if (e_done) gt = -1;
            else if (gt < 0 && (bus.cpu_req_i || bus.dbg_req_i)) begin
                who = bus.dbg_req_i && (!bus.cpu_req_i || !last);
                last = who;
                gt = cyc;
                twe = who ? bus.dbg_we_i : bus.cpu_we_i;
                taddr = who ? bus.dbg_addr_i : bus.cpu_addr_i;
                twd = who ? bus.dbg_wdata_i : bus.cpu_wdata_i;
            end
            step();
            if (e_ack) bus.dbg_req_i = 0;
            else if (!bus.dbg_req_i && $urandom_range(2) == 0) begin
                bus.dbg_req_i = 1; bus.dbg_we_i = 1'($urandom_range(1));
                bus.dbg_addr_i = 32'($urandom_range(63)) << 2; bus.dbg_wdata_i = $urandom;
            end
            if ((bus.cpu_req_i && !e_stall && $urandom_range(1) == 0) || (!bus.cpu_req_i && $urandom_range(2) == 0)) begin
                bus.cpu_req_i = 1; bus.cpu_we_i = 1'($urandom_range(1));
                bus.cpu_addr_i = 32'($urandom_range(63)) << 2; bus.cpu_wdata_i = $urandom;
            end else if (bus.cpu_req_i && (!e_stall || $urandom_range(15) == 0)) bus.cpu_req_i = 0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_load();
        test_arbitration();
        test_alternate();
        test_dbg_write();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
